// File: rtl/apb_periph_arbiter.sv
// apb_periph_arbiter: round-robin share of one APB3 master port between two valid/done requesters.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN. Revision 1.0.
`default_nettype none

module apb_periph_arbiter #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req0_valid_i,
  input  logic [APB_ADDR_WIDTH-1:0] req0_addr_i,
  input  logic                      req0_write_i,
  input  logic [APB_DATA_WIDTH-1:0] req0_wdata_i,
  output logic                      req0_done_o,
  output logic [APB_DATA_WIDTH-1:0] req0_rdata_o,
  output logic                      req0_err_o,
  input  logic                      req1_valid_i,
  input  logic [APB_ADDR_WIDTH-1:0] req1_addr_i,
  input  logic                      req1_write_i,
  input  logic [APB_DATA_WIDTH-1:0] req1_wdata_i,
  output logic                      req1_done_o,
  output logic [APB_DATA_WIDTH-1:0] req1_rdata_o,
  output logic                      req1_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                      state_q;
  logic                        owner_q;
  logic                        rr_last_q;
  logic [APB_ADDR_WIDTH-1:0]   addr_q;
  logic                        write_q;
  logic [APB_DATA_WIDTH-1:0]   wdata_q;
  logic                        psel_q;
  logic                        penable_q;
  logic                        done0_q;
  logic                        done1_q;
  logic [APB_DATA_WIDTH-1:0]   rdata_q;
  logic                        err_q;

  logic                        grant_d;
  logic                        winner_d;

  // The timeout limit only fits a 16-bit counter; out-of-range values are left as a visible marker.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q;
`endif

  assign grant_d  = req0_valid_i | req1_valid_i;
  // On a tie the requester that did not win last time is served.
  assign winner_d = (req0_valid_i && req1_valid_i) ? ~rr_last_q : req1_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_q   <= winner_d;
            rr_last_q <= winner_d;
            addr_q    <= winner_d ? req1_addr_i  : req0_addr_i;
            write_q   <= winner_d ? req1_write_i : req0_write_i;
            wdata_q   <= winner_d ? req1_wdata_i : req0_wdata_i;
            psel_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        ACCESS: begin
          if (pready_i) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= write_q ? '0 : prdata_i;
            err_q     <= pslverr_i;
            done0_q   <= ~owner_q;
            done1_q   <= owner_q;
            state_q   <= RESP;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (cnt_q == TimeoutLimit) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b1;
            done0_q   <= ~owner_q;
            done1_q   <= owner_q;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        RESP: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign paddr_o      = addr_q;
  assign pwdata_o     = wdata_q;
  assign pwrite_o     = write_q;
  assign psel_o       = psel_q;
  assign penable_o    = penable_q;
  assign req0_done_o  = done0_q;
  assign req1_done_o  = done1_q;
  assign req0_rdata_o = done0_q ? rdata_q : '0;
  assign req1_rdata_o = done1_q ? rdata_q : '0;
  assign req0_err_o   = done0_q & err_q;
  assign req1_err_o   = done1_q & err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_periph_arbiter.sv
// tb_apb_periph_arbiter: directed vectors and corner sequences for apb_periph_arbiter.
`default_nettype none

module tb_apb_periph_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [31:0] req0_addr_i = '0, req1_addr_i = '0;
  logic        req0_write_i = 1'b0, req1_write_i = 1'b0;
  logic [31:0] req0_wdata_i = '0, req1_wdata_i = '0;
  logic        req0_done_o, req1_done_o, req0_err_o, req1_err_o;
  logic [31:0] req0_rdata_o, req1_rdata_o;
  logic [31:0] paddr_o, pwdata_o;
  logic        pwrite_o, psel_o, penable_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0, pslverr_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  apb_periph_arbiter #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_write_i(req0_write_i),
    .req0_wdata_i(req0_wdata_i), .req0_done_o(req0_done_o), .req0_rdata_o(req0_rdata_o),
    .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_write_i(req1_write_i),
    .req1_wdata_i(req1_wdata_i), .req1_done_o(req1_done_o), .req1_rdata_o(req1_rdata_o),
    .req1_err_o(req1_err_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .psel_o(psel_o),
    .penable_o(penable_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic set_req(input logic r, input logic v, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (r) begin
      req1_valid_i = v; req1_write_i = wr; req1_addr_i = a; req1_wdata_i = d;
    end else begin
      req0_valid_i = v; req0_write_i = wr; req0_addr_i = a; req0_wdata_i = d;
    end
  endtask

  // Cycle 0 is the IDLE cycle in which valid is first seen.
  task automatic run_vec(input vec_t v);
    int   done_cyc, w, sel_cycles;
    logic [31:0] rd;
    logic er, other_seen, stable_ok, setup_ok, leak;
    done_cyc = -1; w = 0; sel_cycles = 0; rd = '0; er = 1'b0;
    other_seen = 1'b0; stable_ok = 1'b1; setup_ok = 1'b1; leak = 1'b0;
    @(negedge clk_i);
    set_req(v.req, 1'b1, v.wr, v.addr, v.wdata);
    for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
      @(negedge clk_i);
      pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'hBAD0_0000;
      if (cyc == 1 && !(psel_o && !penable_o)) setup_ok = 1'b0;
      if (cyc == 2 && !(psel_o && penable_o)) setup_ok = 1'b0;
      if (psel_o) begin
        sel_cycles++;
        if (paddr_o !== v.addr || pwrite_o !== v.wr || pwdata_o !== v.wdata) stable_ok = 1'b0;
      end
      if (penable_o) begin
        if (w == v.waits) begin
          pready_i = 1'b1; prdata_i = v.prdata; pslverr_i = v.slverr;
        end else begin
          w++;
        end
      end
      if ((v.req ? req0_done_o : req1_done_o) === 1'b1) other_seen = 1'b1;
      if (!req0_done_o && req0_rdata_o !== '0) leak = 1'b1;
      if (!req1_done_o && req1_rdata_o !== '0) leak = 1'b1;
      if ((v.req ? req1_done_o : req0_done_o) === 1'b1) begin
        done_cyc = cyc;
        rd = v.req ? req1_rdata_o : req0_rdata_o;
        er = v.req ? req1_err_o   : req0_err_o;
      end
    end
    set_req(v.req, 1'b0, 1'b0, '0, '0);
    pready_i = 1'b0; pslverr_i = 1'b0;
    check("vec_setup_access_seq", 64'(setup_ok), 64'd1);
    check("vec_done_cycle", 64'(done_cyc), 64'(3 + v.waits));
    check("vec_rdata", 64'(rd), 64'(v.exp_rdata));
    check("vec_err", 64'(er), 64'(v.exp_err));
    check("vec_other_done", 64'(other_seen), 64'd0);
    check("vec_bus_stable", 64'(stable_ok), 64'd1);
    check("vec_psel_cycles", 64'(sel_cycles), 64'(2 + v.waits));
    check("vec_rdata_leak", 64'(leak), 64'd0);
  endtask

  initial begin
    int   grants [8];
    int   g, dones, first_cyc;
    logic done_seen, other_seen, saw_err;
    logic [31:0] rd;

    vecs[0] = '{req:1'b0, wr:1'b0, addr:32'h1A10_0000, wdata:32'h0, prdata:32'h1234_5678,
                waits:0, slverr:1'b0, exp_rdata:32'h1234_5678, exp_err:1'b0};
    vecs[1] = '{req:1'b1, wr:1'b1, addr:32'h1A10_1000, wdata:32'hCAFE_F00D, prdata:32'hDEAD_BEEF,
                waits:3, slverr:1'b0, exp_rdata:32'h0, exp_err:1'b0};
    vecs[2] = '{req:1'b0, wr:1'b0, addr:32'h1A10_2004, wdata:32'h0, prdata:32'hA5A5_5A5A,
                waits:1, slverr:1'b1, exp_rdata:32'hA5A5_5A5A, exp_err:1'b1};
    vecs[3] = '{req:1'b1, wr:1'b0, addr:32'h1A10_3008, wdata:32'h0, prdata:32'h0000_FFFF,
                waits:2, slverr:1'b0, exp_rdata:32'h0000_FFFF, exp_err:1'b0};
    vecs[4] = '{req:1'b0, wr:1'b1, addr:32'h1A10_400C, wdata:32'h0000_0001, prdata:32'h7777_7777,
                waits:0, slverr:1'b1, exp_rdata:32'h0, exp_err:1'b1};

    apply_reset();
    #1;
    check("reset_psel", 64'(psel_o), 64'd0);
    check("reset_penable", 64'(penable_o), 64'd0);
    check("reset_done", 64'({req0_done_o, req1_done_o}), 64'd0);
    check("reset_paddr", 64'(paddr_o), 64'd0);
    check("reset_rdata", 64'({req0_rdata_o, req1_rdata_o}), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Both requesters hold valid from reset; grants must alternate starting with req0.
    apply_reset();
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0100, '0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0000_0200, '0);
    g = 0; dones = 0;
    for (int c = 0; c < 40 && dones < 4; c++) begin
      @(negedge clk_i);
      pready_i = penable_o;
      prdata_i = 32'h0;
      if (psel_o && !penable_o && g < 8) begin
        grants[g] = (paddr_o == 32'h0000_0200) ? 1 : 0;
        g++;
      end
      if (req0_done_o || req1_done_o) dones++;
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; pready_i = 1'b0;
    check("rr_transfers", 64'(dones), 64'd4);
    check("rr_grant0", 64'(grants[0]), 64'd0);
    check("rr_grant1", 64'(grants[1]), 64'd1);
    check("rr_grant2", 64'(grants[2]), 64'd0);
    check("rr_grant3", 64'(grants[3]), 64'd1);

    // Slave never answers.
    apply_reset();
    @(negedge clk_i);
    set_req(1'b0, 1'b1, 1'b0, 32'h1A10_5000, '0);
    first_cyc = -1; saw_err = 1'b0; rd = 32'hFFFF_FFFF;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk_i);
      prdata_i = 32'h5555_AAAA;
      if (req0_done_o && first_cyc < 0) begin
        first_cyc = c; saw_err = req0_err_o; rd = req0_rdata_o;
        req0_valid_i = 1'b0;
      end
    end
`ifdef APB_ARB_TIMEOUT_EN
    check("timeout_done_cycle", 64'(first_cyc), 64'd7);
    check("timeout_err", 64'(saw_err), 64'd1);
    check("timeout_rdata", 64'(rd), 64'd0);
`else
    check("stuck_no_done", 64'(first_cyc), 64'(-1));
    check("stuck_psel_held", 64'({psel_o, penable_o}), 64'd3);
`endif

    // Asynchronous reset in the middle of ACCESS.
    apply_reset();
    @(negedge clk_i);
    set_req(1'b1, 1'b1, 1'b0, 32'h1A10_6000, '0);
    for (int c = 0; c < 10 && !penable_o; c++) @(negedge clk_i);
    @(negedge clk_i);
    check("midreset_in_access", 64'({psel_o, penable_o}), 64'd3);
    #2 rst_ni = 1'b0;
    #1;
    check("midreset_psel_drop", 64'({psel_o, penable_o}), 64'd0);
    req1_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (req0_done_o || req1_done_o) done_seen = 1'b1;
    end
    check("midreset_no_done", 64'(done_seen), 64'd0);
    set_req(1'b1, 1'b1, 1'b0, 32'h1A10_7000, '0);
    set_req(1'b0, 1'b1, 1'b0, 32'h1A10_8000, '0);
    done_seen = 1'b0; other_seen = 1'b0; rd = '0;
    for (int c = 0; c < 10 && !done_seen; c++) begin
      @(negedge clk_i);
      pready_i = penable_o;
      if (psel_o && !penable_o) rd = paddr_o;
      if (req1_done_o) other_seen = 1'b1;
      if (req0_done_o) done_seen = 1'b1;
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; pready_i = 1'b0;
    check("postreset_winner_addr", 64'(rd), 64'h1A10_8000);
    check("postreset_req0_done", 64'(done_seen), 64'd1);
    check("postreset_req1_idle", 64'(other_seen), 64'd0);

    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
